// File: rtl/onehot_decoder_scan.sv
// rtl/onehot_decoder_scan.sv - registered binary-to-one-hot decoder with dwell-timed auto-scan
// All outputs come straight from flops; next-state logic is a single combinational block.
module onehot_decoder_scan #(
    parameter int ADDR_W     = 4,
    parameter int OUT_N      = 16,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    output logic [OUT_N-1:0]  dout,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              valid,
    output logic              wrap,
    output logic              addr_err
);

    localparam int                CNT_W      = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(OUT_N - 1);
    localparam logic [ADDR_W:0]   OUT_LIMIT  = (ADDR_W + 1)'(OUT_N);
    localparam logic [OUT_N-1:0]  DOUT_IDLE  = (ACTIVE_LOW != 0) ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_DIRECT = 2'b01,
        ST_SCAN   = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [OUT_N-1:0]  dout_q, dout_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] scan_idx;

    function automatic logic [OUT_N-1:0] decode(input logic [ADDR_W-1:0] idx);
        logic [OUT_N-1:0] v;
        for (int i = 0; i < OUT_N; i++) begin
            v[i] = (idx == ADDR_W'(i));
        end
        return (ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        cur_d    = cur_q;
        dwell_d  = dwell_q;
        valid_d  = valid_q;
        wrap_d   = 1'b0;
        err_d    = err_q;
        scan_idx = cur_q;

        if (!en) begin
            // Index, dwell and state freeze so a SCAN resumes exactly where it paused.
            dout_d  = DOUT_IDLE;
            valid_d = 1'b0;
        end else begin
            state_d = state_t'(mode);
            case (state_t'(mode))
                ST_OFF: begin
                    dout_d  = DOUT_IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    cur_d   = '0;
                    dwell_d = '0;
                end
                ST_DIRECT: begin
                    dwell_d = '0;
                    if ({1'b0, addr} >= OUT_LIMIT) begin
                        dout_d  = DOUT_IDLE;
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        cur_d   = addr;
                        dout_d  = decode(addr);
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                    end
                end
                ST_SCAN: begin
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    if (state_q != ST_SCAN) begin
                        // Entry always restarts at index 0 and never flags a wrap.
                        scan_idx = '0;
                        dwell_d  = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (cur_q == IDX_LAST) begin
                            scan_idx = '0;
                            wrap_d   = 1'b1;
                        end else begin
                            scan_idx = cur_q + 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                    cur_d  = scan_idx;
                    dout_d = decode(scan_idx);
                end
                ST_HOLD: begin
                    err_d = 1'b0;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            dout_q  <= DOUT_IDLE;
            cur_q   <= '0;
            dwell_q <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign dout     = dout_q;
    assign cur_addr = cur_q;
    assign valid    = valid_q;
    assign wrap     = wrap_q;
    assign addr_err = err_q;

endmodule

// File: tb/tb_onehot_decoder_scan.sv
// tb/tb_onehot_decoder_scan.sv - scoreboard bench for onehot_decoder_scan
module tb_onehot_decoder_scan;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] addr;

    logic [15:0] dout_a;
    logic [3:0]  cur_a;
    logic        valid_a, wrap_a, err_a;
    logic [11:0] dout_b;
    logic [3:0]  cur_b;
    logic        valid_b, wrap_b, err_b;
    logic [15:0] dout_c;
    logic [3:0]  cur_c;
    logic        valid_c, wrap_c, err_c;

    onehot_decoder_scan #(.ADDR_W(4), .OUT_N(16), .DWELL(4), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr),
        .dout(dout_a), .cur_addr(cur_a), .valid(valid_a), .wrap(wrap_a), .addr_err(err_a)
    );

    onehot_decoder_scan #(.ADDR_W(4), .OUT_N(12), .DWELL(4), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr),
        .dout(dout_b), .cur_addr(cur_b), .valid(valid_b), .wrap(wrap_b), .addr_err(err_b)
    );

    onehot_decoder_scan #(.ADDR_W(4), .OUT_N(16), .DWELL(4), .ACTIVE_LOW(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr),
        .dout(dout_c), .cur_addr(cur_c), .valid(valid_c), .wrap(wrap_c), .addr_err(err_c)
    );

    typedef struct packed {
        logic [15:0] dout;
        logic [3:0]  cur;
        logic        valid;
        logic        wrap;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] oh(input int i);
        logic [15:0] v;
        v = 16'd1 << i;
        return v;
    endfunction

    function automatic exp_t mk(input logic [15:0] d, input logic [3:0] c,
                                input logic v, input logic w, input logic e);
        exp_t x;
        x.dout  = d;
        x.cur   = c;
        x.valid = v;
        x.wrap  = w;
        x.err   = e;
        return x;
    endfunction

    task automatic compare_out(input string ctx);
        exp_t x;
        check_eq({ctx, " sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check_eq({ctx, " dout"},     32'(dout_a),  32'(x.dout));
            check_eq({ctx, " cur_addr"}, 32'(cur_a),   32'(x.cur));
            check_eq({ctx, " valid"},    32'(valid_a), 32'(x.valid));
            check_eq({ctx, " wrap"},     32'(wrap_a),  32'(x.wrap));
            check_eq({ctx, " addr_err"}, 32'(err_a),   32'(x.err));
        end
    endtask

    task automatic step(input logic e, input logic [1:0] m, input logic [3:0] a,
                        input exp_t x, input string ctx);
        en   = e;
        mode = m;
        addr = a;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        compare_out(ctx);
    endtask

    initial begin
        int idx;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        addr  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset dout_a",  32'(dout_a),  32'h0);
        check_eq("reset valid_a", 32'(valid_a), 32'h0);
        check_eq("reset cur_a",   32'(cur_a),   32'h0);
        check_eq("reset wrap_a",  32'(wrap_a),  32'h0);
        check_eq("reset err_a",   32'(err_a),   32'h0);
        check_eq("reset dout_c",  32'(dout_c),  32'hFFFF);

        #2;
        rst_n = 1'b1;
        #1;
        check_eq("release dout_a", 32'(dout_a), 32'h0);
        check_eq("release cur_a",  32'(cur_a),  32'h0);
        @(posedge clk);
        #1;
        step(1'b0, 2'b00, 4'd0, mk(16'h0, 4'd0, 1'b0, 1'b0, 1'b0), "idle");

        for (int a = 0; a < 16; a++) begin
            step(1'b1, 2'b01, 4'(a), mk(oh(a), 4'(a), 1'b1, 1'b0, 1'b0), $sformatf("direct a=%0d", a));
            if (a == 3) begin
                check_eq("direct3 dout_c",  32'(dout_c),  32'hFFF7);
                check_eq("direct3 dout_b",  32'(dout_b),  32'h008);
                check_eq("direct3 err_b",   32'(err_b),   32'h0);
            end
            if (a == 13) begin
                check_eq("oor13 dout_b",  32'(dout_b),  32'h0);
                check_eq("oor13 err_b",   32'(err_b),   32'h1);
                check_eq("oor13 valid_b", 32'(valid_b), 32'h0);
                check_eq("oor13 cur_b",   32'(cur_b),   32'd11);
            end
        end
        step(1'b1, 2'b01, 4'd5, mk(16'h0020, 4'd5, 1'b1, 1'b0, 1'b0), "direct a=5");

        for (int k = 0; k <= 89; k++) begin
            idx = (k / 4) % 16;
            step(1'b1, 2'b10, 4'd0, mk(oh(idx), 4'(idx), 1'b1, (k > 0) && (k % 64 == 0), 1'b0),
                 $sformatf("scan k=%0d", k));
        end

        for (int g = 0; g < 5; g++) begin
            step(1'b0, 2'b10, 4'd0, mk(16'h0, 4'd6, 1'b0, 1'b0, 1'b0), $sformatf("en_gap %0d", g));
        end
        check_eq("en_gap dout_c", 32'(dout_c), 32'hFFFF);

        for (int k = 90; k <= 100; k++) begin
            idx = (k / 4) % 16;
            step(1'b1, 2'b10, 4'd0, mk(oh(idx), 4'(idx), 1'b1, 1'b0, 1'b0),
                 $sformatf("resume k=%0d", k));
        end

        for (int h = 0; h < 10; h++) begin
            step(1'b1, 2'b11, 4'd0, mk(oh(9), 4'd9, 1'b1, 1'b0, 1'b0), $sformatf("hold %0d", h));
        end

        for (int k = 0; k <= 4; k++) begin
            idx = k / 4;
            step(1'b1, 2'b10, 4'd0, mk(oh(idx), 4'(idx), 1'b1, 1'b0, 1'b0),
                 $sformatf("rescan k=%0d", k));
        end

        step(1'b1, 2'b00, 4'd0, mk(16'h0, 4'd0, 1'b0, 1'b0, 1'b0), "off");

        for (int k = 0; k <= 5; k++) begin
            idx = k / 4;
            step(1'b1, 2'b10, 4'd0, mk(oh(idx), 4'(idx), 1'b1, 1'b0, 1'b0),
                 $sformatf("prereset k=%0d", k));
        end
        check_eq("prereset cur_c", 32'(cur_c), 32'd1);

        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst dout_c",  32'(dout_c),  32'hFFFF);
        check_eq("async_rst cur_c",   32'(cur_c),   32'h0);
        check_eq("async_rst wrap_c",  32'(wrap_c),  32'h0);
        check_eq("async_rst dout_a",  32'(dout_a),  32'h0);
        check_eq("async_rst cur_a",   32'(cur_a),   32'h0);
        check_eq("async_rst valid_a", 32'(valid_a), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_scan.md
Name: onehot_decoder_scan

Overview:
- Parametrised, registered binary-to-one-hot decoder with an auto-scan mode.
- Generalises the fixed 4-to-16 combinational decoder to any ADDR_W/OUT_N, with selectable output polarity.
- Adds registered outputs, enable, hold, and a dwell-timed sequential sweep of all outputs, for example display digit select or row scanning.
- Sits between control logic and banks of enable lines.

Parameters:
- ADDR_W, 4, address width in bits.
- OUT_N, 16, number of one-hot outputs; legal range 2..2**ADDR_W.
- DWELL, 4, cycles each output stays active in scan mode; must be at least 1.
- ACTIVE_LOW, 0, 1 inverts every bit of dout; the active bit is 0 and all others are 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, global enable.
- mode, input, 2, 00 OFF, 01 DIRECT, 10 SCAN, 11 HOLD.
- addr, input, ADDR_W, select index used in DIRECT mode.
- dout, output, OUT_N, registered one-hot select lines, polarity set by ACTIVE_LOW.
- cur_addr, output, ADDR_W, index currently driven; registered.
- valid, output, 1, high when exactly one dout line is active.
- wrap, output, 1, one-cycle pulse when the scan returns to index 0.
- addr_err, output, 1, high while DIRECT mode holds an out-of-range addr.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - dout goes inactive: all 0, or all 1 if ACTIVE_LOW.
  - cur_addr=0, valid=0, wrap=0, addr_err=0.
  - Dwell counter cleared; internal state goes to OFF.
- Reset release is sampled on the next rising clk edge. Reset mid-operation aborts immediately, and there is no resume state.
- Internal state follows mode at each rising edge when en=1. A mode change takes effect on the edge where it is sampled, so outputs reflect it one cycle later.
- OFF: dout inactive, valid=0, addr_err=0. cur_addr and the dwell counter clear to 0.
- DIRECT: latency is 1 cycle. addr is sampled at edge N and dout[addr] is active after edge N.
  - If addr >= OUT_N: dout inactive, valid=0, addr_err=1, and cur_addr holds its last legal value.
  - Otherwise addr_err=0, valid=1, cur_addr=addr.
- SCAN:
  - On entry from any other state, cur_addr loads 0 and the dwell counter loads 0; dout[0] is active after the entry edge.
  - Each index stays active for exactly DWELL cycles, then cur_addr increments.
  - After index OUT_N-1 the scan wraps to 0. wrap=1 for the single cycle in which cur_addr first reads 0 after a wrap; wrap is never asserted on scan entry.
  - valid=1 throughout SCAN.
- HOLD: dout, cur_addr and valid are frozen and the dwell counter is frozen. Leaving HOLD for SCAN restarts at index 0. Scan entry rules apply because HOLD is a distinct state.
- en=0 (overrides mode):
  - dout inactive, valid=0, wrap=0.
  - cur_addr, dwell counter and internal state are frozen.
  - When en returns to 1 with mode unchanged, a SCAN resumes at the same index and the same remaining dwell. This is not treated as scan entry.
- wrap is only ever a one-cycle pulse; it is never high outside SCAN.
- Arithmetic:
  - The dwell counter is clog2(DWELL)+1 bits wide and counts 0..DWELL-1.
  - The index counter compares against OUT_N-1, not 2**ADDR_W-1, so non-power-of-two OUT_N wraps correctly.
- Outputs are glitch-free: every output is driven directly from a flop.

Test Plan:
- Reset: hold rst_n=0 while clocking → dout=16'h0000, valid=0, cur_addr=0. Deassert rst_n asynchronously mid-cycle → outputs unchanged until mode/en drive them.
- DIRECT sweep: en=1, mode=01, addr=0..15, one per cycle → dout=1<<addr one cycle later, valid=1. Then addr=5 → dout=16'h0020. With OUT_N=12, addr=13 → dout=0, addr_err=1, valid=0, cur_addr keeps its last legal value.
- SCAN with DWELL=4, OUT_N=16: enter SCAN → dout[0] active for 4 cycles, then dout[1], and so on. After 64 cycles cur_addr=0 and wrap=1 for exactly one cycle; wrap=0 on the entry cycle.
- en gap: during SCAN at cur_addr=6 after 2 of 4 dwell cycles, drop en for 5 cycles → dout=0, valid=0. Restore en → index 6 is active for 2 more cycles, then index 7.
- HOLD then SCAN: in SCAN at index 9, set mode=11 for 10 cycles → dout[9] stays active and cur_addr=9. Then set mode=10 → dout[0] after the next edge.
- Polarity and reset mid-scan: ACTIVE_LOW=1, DIRECT addr=3 → dout=16'hFFF7. Assert rst_n=0 mid-SCAN → dout=16'hFFFF immediately without waiting for a clk edge, cur_addr=0, wrap=0.
